// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO and programmable bit divisor.
// Latency: a byte pushed into an empty FIFO while idle starts its start bit 1 clock later.
// Backpressure: none on the bus; a push into a full FIFO is dropped and sets the sticky ovf flag.
module mmio_uart_tx #(
    parameter logic [31:0] BASE        = 32'h0000_0100,
    parameter int          DEPTH       = 4,
    parameter int          DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);
    localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   div_q;
    logic [15:0]   cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [4:0]    count;
    logic          ovf;

    logic          full;
    logic          empty;
    logic          busy;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          stat_wr;
    logic          div_wr;
    logic [15:0]   reload;
    logic [2:0]    nxt_idx;
    logic          unused_bits;

    assign hit      = (a[31:4] == BASE[31:4]);
    assign full     = (count == FULL_CNT);
    assign empty    = (count == 5'd0);
    assign busy     = (state != IDLE);
    assign push_req = we & hit & (a[3:2] == 2'd0);
    assign push     = push_req & ~full;
    assign stat_wr  = we & hit & (a[3:2] == 2'd1);
    assign div_wr   = we & hit & (a[3:2] == 2'd2);
    assign bit_end  = (cnt == 16'd0);
    assign reload   = div_q - 16'd1;
    assign nxt_idx  = idx + 3'd1;
    // The FSM pops whenever it is ready for a new frame and a byte is waiting.
    assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign unused_bits = ^{a[1:0], wd[31:16]};

    always_comb begin
        rd = '0;
        if (hit) begin
            case (a[3:2])
                2'd1:    rd = {23'd0, count, ovf, empty, full, busy};
                2'd2:    rd = {16'd0, div_q};
                default: rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wptr] <= wd[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            div_q <= DIV_RST;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            // An overflow on this edge beats a software clear on the same edge.
            if (push_req && full) begin
                ovf <= 1'b1;
            end else if (stat_wr && wd[3]) begin
                ovf <= 1'b0;
            end
            if (div_wr) begin
                div_q <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= START;
                        shreg <= mem[rptr];
                        tx    <= 1'b0;
                        cnt   <= reload;
                    end
                end
                START: begin
                    if (!bit_end) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        state <= DATA;
                        idx   <= 3'd0;
                        tx    <= shreg[0];
                        cnt   <= reload;
                    end
                end
                DATA: begin
                    if (!bit_end) begin
                        cnt <= cnt - 16'd1;
                    end else if (idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                        cnt   <= reload;
                    end else begin
                        idx <= nxt_idx;
                        tx  <= shreg[nxt_idx];
                        cnt <= reload;
                    end
                end
                STOP: begin
                    if (!bit_end) begin
                        cnt <= cnt - 16'd1;
                    end else if (!empty) begin
                        state <= START;
                        shreg <= mem[rptr];
                        tx    <= 1'b0;
                        cnt   <= reload;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
